// File: rtl/pic_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pic_fetch_sequencer
//
// Instruction-fetch controller for a 14-bit PIC16-style core. It drives the
// address of an asynchronous program ROM and holds a two-stage fetch/execute
// pipeline. GOTO, CALL, RETURN, RETFIE and RETLW are resolved here using a
// circular hardware return stack. Execute-stage skips are also handled here.
// The instruction register and its address are handed to the execute unit.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   en           advance enable; 0 freezes every register (execute stall)
//   rom_addr     ROM address, combinationally equal to the pc register
//   rom_data     ROM word at rom_addr (combinational ROM)
//   skip         squash the instruction following the one currently in ir
//   ir           instruction being executed
//   ir_valid     ir holds a real instruction (0 = bubble, execute as NOP)
//   ir_pc        address of the instruction in ir
//   stack_depth  occupied return-stack entries, saturating 0..STACK_DEPTH
//   stack_ovf    sticky: a push happened while the stack was full
//   stack_unf    sticky: a pop happened while the stack was empty
// ---------------------------------------------------------------------------
module pic_fetch_sequencer #(
  parameter int          ADDR_W      = 11,
  parameter int          STACK_DEPTH = 8,
  parameter int unsigned RESET_VEC   = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  output logic [ADDR_W-1:0]              rom_addr,
  input  logic [13:0]                    rom_data,
  input  logic                           skip,
  output logic [13:0]                    ir,
  output logic                           ir_valid,
  output logic [ADDR_W-1:0]              ir_pc,
  output logic [$clog2(STACK_DEPTH):0]   stack_depth,
  output logic                           stack_ovf,
  output logic                           stack_unf
);

  localparam int SP_W = $clog2(STACK_DEPTH);
  localparam logic [SP_W:0] DEPTH_FULL = (SP_W+1)'(STACK_DEPTH);

  typedef enum logic [1:0] {
    OP_SEQ,
    OP_GOTO,
    OP_CALL,
    OP_RET
  } op_e;

  logic [ADDR_W-1:0] pc;
  logic [SP_W-1:0]   sp;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  op_e               op;
  logic [ADDR_W-1:0] branch_target;
  logic [SP_W-1:0]   sp_dec;

  logic [ADDR_W-1:0] pc_next;
  logic              ir_valid_next;
  logic [SP_W-1:0]   sp_next;
  logic [SP_W:0]     depth_next;
  logic              ovf_next;
  logic              unf_next;
  logic              push;

  assign rom_addr      = pc;
  assign branch_target = ADDR_W'(ir[10:0]);
  assign sp_dec        = sp - SP_W'(1);

  // Classify the word in ir. Bubbles are never decoded, so an invalid ir
  // always looks like a plain sequential instruction.
  always_comb begin
    op = OP_SEQ;
    if (ir_valid) begin
      if (ir[13:11] == 3'b101) begin
        op = OP_GOTO;
      end else if (ir[13:11] == 3'b100) begin
        op = OP_CALL;
      end else if ((ir == 14'h0008) || (ir == 14'h0009) || (ir[13:10] == 4'b1101)) begin
        op = OP_RET;
      end
    end
  end

  // Next-state logic. A taken branch squashes the word that is being fetched
  // at the old pc, so it costs one bubble plus the branch cycle itself. A skip
  // only squashes; fetch carries on sequentially. The depth counter saturates
  // while sp keeps wrapping, which is what makes the stack circular.
  always_comb begin
    pc_next       = pc + ADDR_W'(1);
    ir_valid_next = 1'b1;
    sp_next       = sp;
    depth_next    = stack_depth;
    ovf_next      = stack_ovf;
    unf_next      = stack_unf;
    push          = 1'b0;
    case (op)
      OP_GOTO: begin
        pc_next       = branch_target;
        ir_valid_next = 1'b0;
      end
      OP_CALL: begin
        push          = 1'b1;
        sp_next       = sp + SP_W'(1);
        pc_next       = branch_target;
        ir_valid_next = 1'b0;
        if (stack_depth == DEPTH_FULL) begin
          ovf_next = 1'b1;
        end else begin
          depth_next = stack_depth + (SP_W+1)'(1);
        end
      end
      OP_RET: begin
        pc_next       = stack_mem[sp_dec];
        sp_next       = sp_dec;
        ir_valid_next = 1'b0;
        if (stack_depth == '0) begin
          unf_next = 1'b1;
        end else begin
          depth_next = stack_depth - (SP_W+1)'(1);
        end
      end
      default: begin
        if (ir_valid && skip) begin
          ir_valid_next = 1'b0;
        end
      end
    endcase
  end

  // Pipeline, pc and stack bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= ADDR_W'(RESET_VEC);
      ir          <= 14'h0000;
      ir_valid    <= 1'b0;
      ir_pc       <= '0;
      sp          <= '0;
      stack_depth <= '0;
      stack_ovf   <= 1'b0;
      stack_unf   <= 1'b0;
    end else if (en) begin
      pc          <= pc_next;
      ir          <= rom_data;
      ir_pc       <= pc;
      ir_valid    <= ir_valid_next;
      sp          <= sp_next;
      stack_depth <= depth_next;
      stack_ovf   <= ovf_next;
      stack_unf   <= unf_next;
    end
  end

  // Return-stack storage. Its contents are don't-care after reset, so it has
  // no reset. The pushed value is the current pc, which is ir_pc + 1 whenever
  // a valid CALL sits in ir.
  always_ff @(posedge clk) begin
    if (en && push) begin
      stack_mem[sp] <= pc;
    end
  end

endmodule

// File: tb/tb_pic_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pic_fetch_sequencer
//
// Directed and randomized bench for pic_fetch_sequencer. A program-level
// reference model is kept here: it holds the pc, the word in ir and a
// circular return stack. Every cycle the DUT outputs are compared against
// that model. Directed steps add fixed expected values at the interesting
// points: branch latency, stall, skip, address wrap, stack overflow and
// underflow, and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_pic_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        skip = 1'b0;
  logic [10:0] rom_addr;
  logic [13:0] rom_data;
  logic [13:0] ir;
  logic        ir_valid;
  logic [10:0] ir_pc;
  logic [3:0]  stack_depth;
  logic        stack_ovf;
  logic        stack_unf;

  logic [13:0] rom [0:2047];

  int checks = 0;
  int errors = 0;

  int          m_pc;
  int          m_irpc;
  logic [13:0] m_ir;
  bit          m_valid;
  int          m_depth;
  int          m_sp;
  bit          m_ovf;
  bit          m_unf;
  int          m_stk [8];

  assign rom_data = rom[rom_addr];

  pic_fetch_sequencer #(
    .ADDR_W(11),
    .STACK_DEPTH(8),
    .RESET_VEC(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .skip(skip),
    .ir(ir),
    .ir_valid(ir_valid),
    .ir_pc(ir_pc),
    .stack_depth(stack_depth),
    .stack_ovf(stack_ovf),
    .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  // Instruction class by the ISA rules: 0 plain, 1 GOTO, 2 CALL, 3 return family.
  function automatic int kind_of(input logic [13:0] w);
    if (w[13:11] == 3'b101) return 1;
    if (w[13:11] == 3'b100) return 2;
    if (w == 14'h0008 || w == 14'h0009 || w[13:10] == 4'b1101) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_pc    = 0;
    m_irpc  = 0;
    m_ir    = 14'h0000;
    m_valid = 0;
    m_depth = 0;
    m_sp    = 0;
    m_ovf   = 0;
    m_unf   = 0;
  endtask

  // One clock of the program-level model.
  task automatic model_step(input bit e, input bit s);
    int k;
    int nxt_pc;
    bit nxt_valid;
    if (!e) return;
    k = m_valid ? kind_of(m_ir) : 0;
    nxt_pc = (m_pc + 1) % 2048;
    nxt_valid = 1;
    if (k == 1) begin
      nxt_pc = int'(m_ir[10:0]);
      nxt_valid = 0;
    end else if (k == 2) begin
      m_stk[m_sp] = (m_irpc + 1) % 2048;
      m_sp = (m_sp + 1) % 8;
      if (m_depth == 8) m_ovf = 1;
      else m_depth = m_depth + 1;
      nxt_pc = int'(m_ir[10:0]);
      nxt_valid = 0;
    end else if (k == 3) begin
      m_sp = (m_sp + 7) % 8;
      nxt_pc = m_stk[m_sp];
      if (m_depth == 0) m_unf = 1;
      else m_depth = m_depth - 1;
      nxt_valid = 0;
    end else if (m_valid && s) begin
      nxt_valid = 0;
    end
    m_ir    = rom[m_pc];
    m_irpc  = m_pc;
    m_valid = nxt_valid;
    m_pc    = nxt_pc;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    chk("rom_addr", 32'(rom_addr), m_pc);
    chk("ir_valid", 32'(ir_valid), 32'(m_valid));
    if (m_valid) begin
      chk("ir", 32'(ir), 32'(m_ir));
      chk("ir_pc", 32'(ir_pc), m_irpc);
    end
    chk("stack_depth", 32'(stack_depth), m_depth);
    chk("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
    chk("stack_unf", 32'(stack_unf), 32'(m_unf));
  endtask

  task automatic applyStimulus(input bit e, input bit s);
    en = e;
    skip = s;
    @(posedge clk);
    model_step(e, s);
    #1;
    checkOutput();
  endtask

  task automatic do_reset();
    en = 0;
    skip = 0;
    rst_n = 0;
    model_reset();
    #1;
    checkOutput();
    chk("reset_ir", 32'(ir), 32'h0);
    chk("reset_ir_pc", 32'(ir_pc), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask

  task automatic fill_rom(input logic [13:0] w);
    for (int i = 0; i < 2048; i++) rom[i] = w;
  endtask

  initial begin
    logic [13:0] w;
    int          r;
    bit          e;
    bit          s;

    // Program 1: straight line, CALL/RETURN, stall with CALL in ir, GOTO, skip.
    fill_rom(14'h3000);
    rom[11'h001] = 14'h008D;
    rom[11'h002] = 14'h2019;
    rom[11'h023] = 14'h0008;
    rom[11'h018] = 14'h2800;
    do_reset();
    repeat (3) applyStimulus(1, 0);
    chk("p1_ir_pc_2", 32'(ir_pc), 32'h2);
    chk("p1_valid", 32'(ir_valid), 32'h1);
    repeat (5) begin
      applyStimulus(0, 0);
      chk("stall_addr", 32'(rom_addr), 32'h3);
      chk("stall_ir_pc", 32'(ir_pc), 32'h2);
    end
    applyStimulus(1, 0);
    chk("call_addr", 32'(rom_addr), 32'h019);
    chk("call_bubble", 32'(ir_valid), 32'h0);
    chk("call_depth", 32'(stack_depth), 32'h1);
    repeat (11) applyStimulus(1, 0);
    chk("sub_ret_in_ir", 32'(ir_pc), 32'h023);
    applyStimulus(1, 0);
    chk("ret_addr", 32'(rom_addr), 32'h003);
    chk("ret_bubble", 32'(ir_valid), 32'h0);
    chk("ret_depth", 32'(stack_depth), 32'h0);
    applyStimulus(1, 0);
    chk("ret_target_pc", 32'(ir_pc), 32'h003);
    chk("ret_target_ir", 32'(ir), 32'h3000);
    repeat (21) applyStimulus(1, 0);
    chk("goto_in_ir", 32'(ir_pc), 32'h018);
    applyStimulus(1, 0);
    chk("goto_addr", 32'(rom_addr), 32'h000);
    chk("goto_bubble", 32'(ir_valid), 32'h0);
    applyStimulus(1, 0);
    chk("goto_target", 32'(ir_pc), 32'h000);
    applyStimulus(1, 1);
    chk("skip_squash", 32'(ir_valid), 32'h0);
    applyStimulus(1, 0);
    chk("after_skip_pc", 32'(ir_pc), 32'h002);
    chk("after_skip_valid", 32'(ir_valid), 32'h1);

    // Program 2: address wrap at the top of the ROM.
    fill_rom(14'h3000);
    rom[11'h000] = 14'h2FFE;
    rom[11'h7FF] = 14'h2FFF;
    do_reset();
    repeat (3) applyStimulus(1, 0);
    chk("wrap_7fe", 32'(ir_pc), 32'h7FE);
    applyStimulus(1, 0);
    chk("wrap_7ff", 32'(ir_pc), 32'h7FF);
    chk("wrap_addr0", 32'(rom_addr), 32'h000);
    applyStimulus(1, 0);
    chk("self_goto_addr", 32'(rom_addr), 32'h7FF);
    applyStimulus(1, 0);
    chk("self_goto_ir_pc", 32'(ir_pc), 32'h7FF);
    chk("self_goto_wrap", 32'(rom_addr), 32'h000);

    // Program 3: nine nested CALLs, then nine RETURNs.
    fill_rom(14'h3000);
    rom[11'h000] = 14'h2900;
    for (int k = 0; k < 9; k++) begin
      rom[11'h100 + 11'(16 * k)] = 14'h2000 | 14'(16'h110 + 16 * k);
      rom[11'h101 + 11'(16 * k)] = 14'h0008;
    end
    rom[11'h190] = 14'h0008;
    do_reset();
    for (int step = 1; step <= 38; step++) begin
      applyStimulus(1, 0);
      if (step == 19) begin
        chk("pre_ovf_flag", 32'(stack_ovf), 32'h0);
        chk("pre_ovf_depth", 32'(stack_depth), 32'h8);
      end
      if (step == 20) begin
        chk("ovf_flag", 32'(stack_ovf), 32'h1);
        chk("ovf_depth", 32'(stack_depth), 32'h8);
      end
      if (step == 36) chk("pre_unf_flag", 32'(stack_unf), 32'h0);
      if (step > 20 && (step % 2) == 0) begin
        if (step < 38) chk("pop_target", 32'(rom_addr), 32'(32'h191 - 16 * ((step - 20) / 2)));
        else begin
          chk("unf_target", 32'(rom_addr), 32'h181);
          chk("unf_flag", 32'(stack_unf), 32'h1);
          chk("unf_depth", 32'(stack_depth), 32'h0);
        end
      end
    end

    // Asynchronous reset just after the overflowing CALL.
    do_reset();
    repeat (20) applyStimulus(1, 0);
    chk("pre_areset_ovf", 32'(stack_ovf), 32'h1);
    #2 rst_n = 0;
    #1;
    chk("areset_addr", 32'(rom_addr), 32'h0);
    chk("areset_valid", 32'(ir_valid), 32'h0);
    chk("areset_depth", 32'(stack_depth), 32'h0);
    chk("areset_ovf", 32'(stack_ovf), 32'h0);
    chk("areset_unf", 32'(stack_unf), 32'h0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1;

    // Random program behind a prologue that fills all eight stack entries.
    for (int i = 0; i < 2048; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    w = 14'h2800 | 14'($urandom_range(0, 2047));
        2:       w = 14'h2000 | 14'($urandom_range(0, 2047));
        3:       w = 14'h0008;
        4:       w = 14'h0009;
        5:       w = 14'h3400 | 14'($urandom_range(0, 255));
        default: w = 14'($urandom_range(0, 2047));
      endcase
      rom[i] = w;
    end
    rom[11'h000] = 14'h2900;
    for (int k = 0; k < 8; k++) rom[11'h100 + 11'(16 * k)] = 14'h2000 | 14'(16'h110 + 16 * k);
    rom[11'h180] = 14'h2A00;
    do_reset();
    repeat (1500) begin
      e = ($urandom_range(0, 9) < 8);
      s = ($urandom_range(0, 2) == 0);
      applyStimulus(e, s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
